// File: rtl/state_mon_pkg.sv
// Shared types and default sizing for the state dwell monitor.
package state_mon_pkg;

  localparam int unsigned CW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned AW_DEF    = 2;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]        state;
    logic [CW_DEF-1:0] dwell;
  } rec_t;

endpackage

// File: rtl/state_dwell_monitor_rec_fifo.sv
// Synchronous first-word-fall-through FIFO holding dwell records.
module rec_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [AW:0]   cnt,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign cnt     = cnt_q;
  assign rdata   = valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/state_dwell_monitor.sv
// Measures per-visit dwell of a 2-bit state bus and queues {state, dwell} records.
// Define STATE_HIST_EN to add per-state saturating visit counters on hist_cnt.
module state_dwell_monitor
  import state_mon_pkg::*;
#(
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    state_in,
  input  logic          rec_ready,
  output logic          rec_valid,
  output logic [1:0]    rec_state,
  output logic [CW-1:0] rec_dwell,
  output logic [AW:0]   fifo_cnt,
`ifdef STATE_HIST_EN
  output logic [4*CW-1:0] hist_cnt,
`endif
  output logic          overflow
);

  state_e          cur_q;
  logic [CW-1:0]   dwell_q;
  logic            armed_q;
  logic            overflow_q;
  logic            change;
  logic            full;
  logic [CW+1:0]   rdata;

  assign change = armed_q && (state_in != cur_q);

  rec_fifo #(
    .W     (CW + 2),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (change),
    .pop   (rec_ready),
    .wdata ({cur_q, dwell_q}),
    .rdata (rdata),
    .valid (rec_valid),
    .cnt   (fifo_cnt),
    .full  (full)
  );

  assign rec_state = rdata[CW+1:CW];
  assign rec_dwell = rdata[CW-1:0];
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q      <= S0;
      dwell_q    <= '0;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (!armed_q) begin
      cur_q   <= state_e'(state_in);
      dwell_q <= CW'(1);
      armed_q <= 1'b1;
    end else if (change) begin
      cur_q   <= state_e'(state_in);
      dwell_q <= CW'(1);
      // Full with no pop on this edge means the record is lost.
      if (full && !rec_ready) overflow_q <= 1'b1;
    end else if (dwell_q != '1) begin
      dwell_q <= dwell_q + CW'(1);
    end
  end

`ifdef STATE_HIST_EN
  logic [3:0][CW-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
    end else if ((!armed_q || change) && (hist_q[state_in] != '1)) begin
      hist_q[state_in] <= hist_q[state_in] + CW'(1);
    end
  end

  assign hist_cnt = hist_q;
`endif

endmodule

// File: tb/tb_state_dwell_monitor.sv
// Randomised and directed scoreboard bench for state_dwell_monitor.
module tb_state_dwell_monitor;

  localparam int CW    = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    state_in = 2'd0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [1:0]    rec_state;
  logic [CW-1:0] rec_dwell;
  logic [AW:0]   fifo_cnt;
  logic          overflow;
`ifdef STATE_HIST_EN
  logic [4*CW-1:0] hist_cnt;
`endif

  state_dwell_monitor #(
    .CW    (CW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .rec_ready (rec_ready),
    .rec_valid (rec_valid),
    .rec_state (rec_state),
    .rec_dwell (rec_dwell),
    .fifo_cnt  (fifo_cnt),
`ifdef STATE_HIST_EN
    .hist_cnt  (hist_cnt),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int dw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  bit   started = 1'b0;
  bit   m_armed = 1'b0;
  int   m_cur = 0;
  int   m_len = 0;
  bit   m_ovf = 1'b0;
  int   m_hist[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a visit ends on a change; its record is dropped if the queue is full.
  task automatic model_step();
    exp_t r;
    int   s;
    started = 1'b1;
    s = int'(state_in);
    if (!rst) begin
      exp_q.delete();
      m_armed = 1'b0;
      m_ovf   = 1'b0;
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
      m_cur   = s;
      m_len   = 1;
      if (m_hist[s] < SAT) m_hist[s]++;
    end else if (s == m_cur) begin
      m_len++;
    end else begin
      r.st = m_cur;
      r.dw = (m_len > SAT) ? SAT : m_len;
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else m_ovf = 1'b1;
      m_cur = s;
      m_len = 1;
      if (m_hist[s] < SAT) m_hist[s]++;
    end
  endtask

  // Monitor: compare at negedge; a pop seen here happens on the next posedge.
  task automatic monitor_step();
    if (!started) return;
    chk("rec_valid", int'(rec_valid), int'(exp_q.size() != 0));
    chk("fifo_cnt", int'(fifo_cnt), exp_q.size());
    chk("overflow", int'(overflow), int'(m_ovf));
`ifdef STATE_HIST_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("hist_cnt[%0d]", k), int'(hist_cnt[k*CW +: CW]), m_hist[k]);
`endif
    if (exp_q.size() > 0) begin
      if (rec_valid) begin
        chk("rec_state", int'(rec_state), exp_q[0].st);
        chk("rec_dwell", int'(rec_dwell), exp_q[0].dw);
      end
      if (rec_ready) begin
        void'(exp_q.pop_front());
        if (rec_valid) pops++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic step(input int s, input bit r);
    state_in  = 2'(s);
    rec_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0, 1'b0);
    rst = 1'b1;
  endtask

  int p0;

  initial begin
    // Reset held with state toggling
    for (int i = 0; i < 3; i++) step(i % 2 + 1, 1'b1);
    chk("reset rec_valid", int'(rec_valid), 0);
    chk("reset rec_dwell", int'(rec_dwell), 0);
    rst = 1'b1;

    // Basic: S0 x3, S1 x5, S2
    p0 = pops;
    for (int i = 0; i < 3; i++) step(0, 1'b1);
    for (int i = 0; i < 5; i++) step(1, 1'b1);
    step(2, 1'b1);
    for (int i = 0; i < 3; i++) step(2, 1'b1);
    chk("basic record count", pops - p0, 2);

    // Saturation: S2 held 20 then S3
    do_reset();
    for (int i = 0; i < 20; i++) step(2, 1'b1);
    for (int i = 0; i < 3; i++) step(3, 1'b1);

    // Overflow: 6 changes with no consumer
    do_reset();
    step(0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(i % 4, 1'b0);
      step(i % 4, 1'b0);
    end
    chk("overflow fifo_cnt", int'(fifo_cnt), DEPTH);
    chk("overflow flag", int'(overflow), 1);
    p0 = pops;
    for (int i = 0; i < 6; i++) step(2, 1'b1);
    chk("overflow drained", pops - p0, DEPTH);

    // Full + push + pop on the same edge
    do_reset();
    step(0, 1'b0);
    step(1, 1'b0);
    step(2, 1'b0);
    step(3, 1'b0);
    step(0, 1'b0);
    chk("full fifo_cnt", int'(fifo_cnt), DEPTH);
    step(1, 1'b1);
    chk("push+pop fifo_cnt", int'(fifo_cnt), DEPTH);
    chk("push+pop overflow", int'(overflow), 0);
    for (int i = 0; i < 6; i++) step(1, 1'b1);

    // Reset mid-visit with two records queued
    do_reset();
    step(0, 1'b0);
    step(1, 1'b0);
    step(2, 1'b0);
    step(2, 1'b0);
    chk("pre-reset fifo_cnt", int'(fifo_cnt), 2);
    do_reset();
    chk("post-reset fifo_cnt", int'(fifo_cnt), 0);
    p0 = pops;
    step(1, 1'b1);
    step(1, 1'b1);
    step(0, 1'b1);
    for (int i = 0; i < 4; i++) step(0, 1'b1);
    chk("post-reset records", pops - p0, 1);

    // Random traffic with occasional resets
    begin
      int s;
      s = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 2) == 0) s = int'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) rst = 1'b0;
        else rst = 1'b1;
        step(s, 1'($urandom_range(0, 3) == 0 ? 1 : $urandom_range(0, 1)));
      end
      rst = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step(s, 1'b1);
      chk("final drain", int'(rec_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
